// File: rtl/md_mem_pkg.sv
// Shared definitions for the particle-position memories: channel indices,
// default geometry, FSM state encoding and a packed-bus channel extractor.
package md_mem_pkg;

    localparam int CH_X = 0;
    localparam int CH_Y = 1;
    localparam int CH_Z = 2;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 512;
    localparam int DEF_ADDR_WIDTH = 9;

    // Widest packed bus / channel word the extractor below can handle.
    localparam int MAX_BUS_WIDTH  = 1024;
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Returns channel ch of a packed bus, LSB-aligned; callers truncate to their width.
    function automatic logic [MAX_DATA_WIDTH-1:0] chan_slice(
        input logic [MAX_BUS_WIDTH-1:0] bus,
        input int                       ch,
        input int                       width
    );
        return MAX_DATA_WIDTH'(bus >> (ch * width));
    endfunction

endpackage

// File: rtl/sdp_ram_1w1r.sv
// Single-channel simple dual-port RAM: one write port, one enabled synchronous
// read port, and an optional enabled output register for a second read stage.
module sdp_ram_1w1r #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter bit OUT_REG    = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_out_en,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q1;
    logic [DATA_WIDTH-1:0] r_q2;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-old-data behaviour; same-address bypass is resolved by the caller.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_q1 <= '0;
        end else if (i_re) begin
            r_q1 <= r_mem[i_raddr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_q2 <= '0;
        end else if (i_out_en) begin
            r_q2 <= r_q1;
        end
    end

    assign o_rdata = OUT_REG ? r_q2 : r_q1;

endmodule

// File: rtl/pos_cache_xyz.sv
// Per-particle coordinate store: masked writes, fixed-latency reads with
// write-first bypass, a zero-fill sweep after reset/clear and a particle count.
module pos_cache_xyz
    import md_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int NUM_CHANNELS = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                               i_clock,
    input  logic                               i_rst,
    input  logic                               i_clear,
    output logic                               o_ready,
    input  logic                               i_wr_en,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [NUM_CHANNELS-1:0]            i_wr_mask,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_wr_data,
    input  logic                               i_rd_en,
    input  logic [ADDR_WIDTH-1:0]              i_rd_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_rd_data,
    output logic                               o_rd_valid,
    output logic [ADDR_WIDTH:0]                o_particle_count
);

    localparam int                  BUS_WIDTH = NUM_CHANNELS * DATA_WIDTH;
    localparam int                  MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit                  OUT_REG   = (READ_LATENCY == 2);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_sweep_addr;
    logic                    r_ready;
    logic [ADDR_WIDTH:0]     r_count;

    logic                    r_v1;
    logic                    r_v2;
    logic                    r_oor1;
    logic                    r_oor2;
    logic [NUM_CHANNELS-1:0] r_bmask1;
    logic [NUM_CHANNELS-1:0] r_bmask2;
    logic [BUS_WIDTH-1:0]    r_bdata1;
    logic [BUS_WIDTH-1:0]    r_bdata2;

    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_wr_ok;
    logic                    w_rd_in;
    logic                    w_sweeping;
    logic                    w_ram_re;
    logic [ADDR_WIDTH:0]     w_wr_next;
    logic [NUM_CHANNELS-1:0] w_byp_mask;
    logic [MEM_AW-1:0]       w_ram_waddr;
    logic                    w_oor;
    logic [NUM_CHANNELS-1:0] w_bmask;
    logic [BUS_WIDTH-1:0]    w_bdata;

    assign w_wr_acc    = r_ready & i_wr_en;
    assign w_rd_acc    = r_ready & i_rd_en;
    assign w_wr_ok     = w_wr_acc & ({1'b0, i_wr_addr} < DEPTH_W);
    assign w_rd_in     = ({1'b0, i_rd_addr} < DEPTH_W);
    assign w_ram_re    = w_rd_acc & w_rd_in;
    assign w_wr_next   = {1'b0, i_wr_addr} + (ADDR_WIDTH + 1)'(1);
    assign w_sweeping  = (r_state == ST_CLEAR);
    assign w_ram_waddr = w_sweeping ? r_sweep_addr[MEM_AW-1:0] : i_wr_addr[MEM_AW-1:0];
    assign w_byp_mask  = (w_wr_ok && (i_wr_addr == i_rd_addr)) ? i_wr_mask : '0;

    // A clear arriving with a write lets the write land, then zeroes the count;
    // the sweep wipes that write anyway.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_state      <= ST_CLEAR;
            r_sweep_addr <= '0;
            r_ready      <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_addr == LAST_ADDR) begin
                        r_state      <= ST_RUN;
                        r_ready      <= 1'b1;
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        r_state      <= ST_CLEAR;
                        r_ready      <= 1'b0;
                        r_sweep_addr <= '0;
                        r_count      <= '0;
                    end else if (w_wr_ok && (w_wr_next > r_count)) begin
                        r_count <= w_wr_next;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bypass and out-of-range info travels alongside the RAM data so that each
    // stage holds its value while no new read is moving through it.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_oor1   <= 1'b0;
            r_oor2   <= 1'b0;
            r_bmask1 <= '0;
            r_bmask2 <= '0;
            r_bdata1 <= '0;
            r_bdata2 <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            r_v2 <= r_v1;
            if (w_rd_acc) begin
                r_oor1   <= ~w_rd_in;
                r_bmask1 <= w_byp_mask;
                r_bdata1 <= i_wr_data;
            end
            if (r_v1) begin
                r_oor2   <= r_oor1;
                r_bmask2 <= r_bmask1;
                r_bdata2 <= r_bdata1;
            end
        end
    end

    assign w_oor   = OUT_REG ? r_oor2   : r_oor1;
    assign w_bmask = OUT_REG ? r_bmask2 : r_bmask1;
    assign w_bdata = OUT_REG ? r_bdata2 : r_bdata1;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] w_wdata;
        logic [DATA_WIDTH-1:0] w_ram_wdata;
        logic [DATA_WIDTH-1:0] w_ram_q;
        logic [DATA_WIDTH-1:0] w_byp_data;
        logic                  w_ram_we;

        assign w_wdata     = DATA_WIDTH'(chan_slice(MAX_BUS_WIDTH'(i_wr_data), c, DATA_WIDTH));
        assign w_byp_data  = DATA_WIDTH'(chan_slice(MAX_BUS_WIDTH'(w_bdata), c, DATA_WIDTH));
        assign w_ram_we    = w_sweeping | (w_wr_ok & i_wr_mask[c]);
        assign w_ram_wdata = w_sweeping ? '0 : w_wdata;

        sdp_ram_1w1r #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (MEM_AW),
            .OUT_REG    (OUT_REG)
        ) u_ram (
            .i_clock  (i_clock),
            .i_rst    (i_rst),
            .i_we     (w_ram_we),
            .i_waddr  (w_ram_waddr),
            .i_wdata  (w_ram_wdata),
            .i_re     (w_ram_re),
            .i_raddr  (i_rd_addr[MEM_AW-1:0]),
            .i_out_en (r_v1),
            .o_rdata  (w_ram_q)
        );

        assign o_rd_data[c*DATA_WIDTH +: DATA_WIDTH] =
            w_oor ? '0 : (w_bmask[c] ? w_byp_data : w_ram_q);
    end

    assign o_ready          = r_ready;
    assign o_rd_valid       = OUT_REG ? r_v2 : r_v1;
    assign o_particle_count = r_count;

endmodule

// File: tb/tb_pos_cache_xyz.sv
// Bench for pos_cache_xyz: a latency-2 and a latency-1 instance share stimulus;
// a cycle-level reference model fills per-instance scoreboards of expected reads.
module tb_pos_cache_xyz;
    import md_mem_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int NCH   = 3;
    localparam int BW    = NCH * DW;

    logic          clock  = 1'b0;
    logic          rst    = 1'b1;
    logic          clear  = 1'b0;
    logic          wrEn   = 1'b0;
    logic          rdEn   = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [AW-1:0] rdAddr = '0;
    logic [NCH-1:0] wrMask = '0;
    logic [BW-1:0] wrData = '0;

    logic          ready2, rdValid2, ready1, rdValid1;
    logic [BW-1:0] rdData2, rdData1;
    logic [AW:0]   count2, count1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0]   due;
        logic [BW-1:0] data;
    } sbEntry_t;

    sbEntry_t sbQ2[$];
    sbEntry_t sbQ1[$];

    logic [DW-1:0] mMem [DEPTH][NCH];
    logic          mReady = 1'b0;
    logic [3:0]    mSweep = '0;
    int            mCount = 0;
    logic [BW-1:0] last2 = '0;
    logic [BW-1:0] last1 = '0;

    always #5 clock = ~clock;

    pos_cache_xyz #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .NUM_CHANNELS(NCH), .READ_LATENCY(2)
    ) dut (
        .i_clock(clock), .i_rst(rst), .i_clear(clear), .o_ready(ready2),
        .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_mask(wrMask), .i_wr_data(wrData),
        .i_rd_en(rdEn), .i_rd_addr(rdAddr), .o_rd_data(rdData2), .o_rd_valid(rdValid2),
        .o_particle_count(count2)
    );

    pos_cache_xyz #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .NUM_CHANNELS(NCH), .READ_LATENCY(1)
    ) dutLat1 (
        .i_clock(clock), .i_rst(rst), .i_clear(clear), .o_ready(ready1),
        .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_mask(wrMask), .i_wr_data(wrData),
        .i_rd_en(rdEn), .i_rd_addr(rdAddr), .o_rd_data(rdData1), .o_rd_valid(rdValid1),
        .o_particle_count(count1)
    );

    // Reference model: decides acceptance from its own ready, computes write-first
    // read data before applying this cycle's write, and queues it with its due cycle.
    always @(posedge clock) begin
        logic [BW-1:0] expData;
        expData = '0;
        if (rst) begin
            mReady = 1'b0;
            mSweep = '0;
            mCount = 0;
            sbQ1.delete();
            sbQ2.delete();
            last1 = '0;
            last2 = '0;
        end else if (!mReady) begin
            for (int ch = 0; ch < NCH; ch++) mMem[mSweep][ch] = '0;
            if (mSweep == 4'(DEPTH - 1)) mReady = 1'b1;
            mSweep = mSweep + 4'd1;
        end else begin
            if (rdEn) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (int'(rdAddr) >= DEPTH)
                        expData[ch*DW +: DW] = '0;
                    else if (wrEn && int'(wrAddr) < DEPTH && wrAddr == rdAddr && wrMask[ch])
                        expData[ch*DW +: DW] = wrData[ch*DW +: DW];
                    else
                        expData[ch*DW +: DW] = mMem[rdAddr[3:0]][ch];
                end
                sbQ1.push_back({32'(cyc + 1), expData});
                sbQ2.push_back({32'(cyc + 2), expData});
            end
            if (wrEn && int'(wrAddr) < DEPTH) begin
                for (int ch = 0; ch < NCH; ch++)
                    if (wrMask[ch]) mMem[wrAddr[3:0]][ch] = wrData[ch*DW +: DW];
                if (int'(wrAddr) + 1 > mCount) mCount = int'(wrAddr) + 1;
            end
            if (clear) begin
                mReady = 1'b0;
                mSweep = '0;
                mCount = 0;
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic checkOutput();
        check("ready_l2", 128'(ready2), 128'(mReady));
        check("ready_l1", 128'(ready1), 128'(mReady));
        check("count_l2", 128'(count2), 128'(mCount));
        check("count_l1", 128'(count1), 128'(mCount));
        if (sbQ2.size() > 0 && int'(sbQ2[0].due) == cyc) begin
            check("valid_l2", 128'(rdValid2), 128'(1));
            check("data_l2", 128'(rdData2), 128'(sbQ2[0].data));
            last2 = sbQ2[0].data;
            void'(sbQ2.pop_front());
        end else begin
            check("idle_l2", 128'(rdValid2), 128'(0));
            check("hold_l2", 128'(rdData2), 128'(last2));
        end
        if (sbQ1.size() > 0 && int'(sbQ1[0].due) == cyc) begin
            check("valid_l1", 128'(rdValid1), 128'(1));
            check("data_l1", 128'(rdData1), 128'(sbQ1[0].data));
            last1 = sbQ1[0].data;
            void'(sbQ1.pop_front());
        end else begin
            check("idle_l1", 128'(rdValid1), 128'(0));
            check("hold_l1", 128'(rdData1), 128'(last1));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [NCH-1:0] wm,
                                 input logic [BW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                                 input logic clr);
        wrEn = we; wrAddr = wa; wrMask = wm; wrData = wd;
        rdEn = re; rdAddr = ra; clear = clr;
        tick();
        wrEn = 1'b0; rdEn = 1'b0; clear = 1'b0; wrMask = '0;
    endtask

    task automatic doWrite(input logic [AW-1:0] wa, input logic [NCH-1:0] wm, input logic [BW-1:0] wd);
        applyStimulus(1'b1, wa, wm, wd, 1'b0, '0, 1'b0);
    endtask

    task automatic doRead(input logic [AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, ra, 1'b0);
    endtask

    task automatic waitReady(input string tag, input int expN);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            tick();
            n    = k;
            seen = ready2;
        end
        check(tag, 128'(n), 128'(expN));
    endtask

    function automatic logic [BW-1:0] pack3(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                             input logic [DW-1:0] z);
        logic [BW-1:0] v;
        v = '0;
        v[CH_X*DW +: DW] = x;
        v[CH_Y*DW +: DW] = y;
        v[CH_Z*DW +: DW] = z;
        return v;
    endfunction

    initial begin
        $display("[TB] pos_cache_xyz bench, DEPTH=%0d", DEPTH);
        @(negedge clock);
        repeat (3) tick();

        // Sweep after reset release, then every address reads back zero.
        rst = 1'b0;
        waitReady("sweep_len", DEPTH);
        for (int a = 0; a < DEPTH; a++) doRead(AW'(a));
        doRead(AW'(20));
        repeat (3) tick();

        // Latency: the latency-1 instance answers one cycle ahead of latency-2.
        doWrite(5'd5, 3'b111, pack3(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000));
        doRead(5'd5);
        check("lat1_valid", 128'(rdValid1), 128'(1));
        check("lat1_data", 128'(rdData1), 128'(pack3(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000)));
        check("lat2_early", 128'(rdValid2), 128'(0));
        tick();
        check("lat2_valid", 128'(rdValid2), 128'(1));
        check("lat2_data", 128'(rdData2), 128'(pack3(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000)));
        tick();

        // Masked write-first bypass on a same-cycle read.
        doWrite(5'd7, 3'b111, pack3(32'h55, 32'h11, 32'hAAA));
        applyStimulus(1'b1, 5'd7, 3'b010, pack3(32'hDEAD, 32'h22, 32'hBEEF), 1'b1, 5'd7, 1'b0);
        tick();
        check("bypass_mask", 128'(rdData2), 128'(pack3(32'h55, 32'h22, 32'hAAA)));
        doRead(5'd7);
        doWrite(5'd7, 3'b101, pack3(32'h66, 32'h33, 32'h77));
        check("no_late_write", 128'(rdData2), 128'(pack3(32'h55, 32'h22, 32'hAAA)));
        doRead(5'd7);
        repeat (3) tick();

        // Clear during traffic: in-flight and clear-cycle requests complete.
        doRead(5'd5);
        doRead(5'd7);
        doRead(5'd3);
        applyStimulus(1'b1, 5'd9, 3'b111, pack3(32'h1, 32'h2, 32'h3), 1'b1, 5'd5, 1'b1);
        applyStimulus(1'b1, 5'd4, 3'b111, pack3(32'h9, 32'h9, 32'h9), 1'b1, 5'd5, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b1);
        repeat (3) doWrite(5'd6, 3'b111, pack3(32'h8, 32'h8, 32'h8));
        waitReady("clear_len", DEPTH - 5);
        check("clear_count", 128'(count2), 128'(0));
        doRead(5'd9);
        doRead(5'd7);
        doRead(5'd6);
        repeat (3) tick();

        // Particle count tracks the highest in-range index written.
        doWrite(5'd3, 3'b001, pack3(32'h1, 32'h0, 32'h0));
        check("count_a3", 128'(count2), 128'(4));
        doWrite(5'd10, 3'b111, pack3(32'hA1, 32'hA2, 32'hA3));
        check("count_a10", 128'(count2), 128'(11));
        doWrite(5'd2, 3'b111, pack3(32'h4, 32'h5, 32'h6));
        check("count_a2", 128'(count2), 128'(11));
        doWrite(5'd20, 3'b111, pack3(32'hF, 32'hF, 32'hF));
        check("count_oor", 128'(count2), 128'(11));
        doWrite(5'd12, 3'b000, pack3(32'hE, 32'hE, 32'hE));
        check("count_mask0", 128'(count2), 128'(13));
        doRead(5'd12);
        doRead(5'd10);
        repeat (3) tick();

        // Reset one cycle after a read: no latency-2 valid, sweep restarts.
        doRead(5'd10);
        rst = 1'b1;
        tick();
        check("rst_flush", 128'(rdValid2), 128'(0));
        rst = 1'b0;
        waitReady("rst_sweep_len", DEPTH);
        doRead(5'd10);
        tick();
        check("rst_swept", 128'(rdData2), 128'(0));
        repeat (3) tick();

        check("sb_drained", 128'(sbQ2.size() + sbQ1.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pos_cache_xyz.md
Name: pos_cache_xyz

Overview:
Parametrised particle-position store holding NUM_CHANNELS coordinate channels (default x/y/z) per particle in one block. It has one write port, used by the motion-update stage, and one independent read port, used by the force pipeline. Writes are per-channel masked. It provides a fixed, configurable read latency with a valid strobe, write-first same-address bypass, a hardware clear sweep, and a running particle count.

Parameters:
DATA_WIDTH, 32, bits per coordinate word
DEPTH, 512, particles per channel
ADDR_WIDTH, 9, address width; DEPTH <= 2**ADDR_WIDTH
NUM_CHANNELS, 3, coordinate channels; channel 0 occupies the LSBs of packed buses
READ_LATENCY, 2, cycles from accepted rd_en to rd_valid; legal values 1 or 2

Ports:
clock  in  1  single clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  pulse; starts a zero-fill sweep when idle
ready  out  1  high when reads and writes are accepted
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write particle index
wr_mask  in  NUM_CHANNELS  per-channel write enable
wr_data  in  NUM_CHANNELS*DATA_WIDTH  packed write data
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read particle index
rd_data  out  NUM_CHANNELS*DATA_WIDTH  packed read data, all channels
rd_valid  out  1  rd_data valid this cycle
particle_count  out  ADDR_WIDTH+1  highest written index + 1 since the last clear

Behaviour:
- FSM states: CLEAR and RUN.
  - rst forces CLEAR with sweep address 0.
  - In CLEAR, one address per cycle is written to zero in all channels. After address DEPTH-1 is written, the FSM moves to RUN.
  - clear seen in RUN moves the FSM to CLEAR at address 0. clear seen in CLEAR is ignored; the sweep does not restart.
- Clear-sweep timing: if c0 is the first cycle with rst low, addresses 0..DEPTH-1 are written in c0..c(DEPTH-1), and ready=1 from c(DEPTH). ready=0 throughout CLEAR.
- Reset values: ready=0, rd_valid=0, rd_data=0, particle_count=0, read pipeline flushed.
- Request acceptance: a request is accepted only when ready=1. Requests made while ready=0 are dropped with no side effects and no rd_valid.
- Write:
  - Accepted wr_en updates only the channels whose wr_mask bit is set. Unmasked channels keep their contents.
  - wr_mask=0 is a legal no-op, but it still updates particle_count.
- Read:
  - Accepted rd_en at cycle r produces rd_valid=1 and rd_data at cycle r+READ_LATENCY.
  - Back-to-back reads are accepted every cycle, and results return in order.
  - When rd_valid=0, rd_data holds its last value.
- Same-cycle same-address read/write: write-first.
  - Channels with the mask bit set return the new wr_data.
  - Unmasked channels return the stored value.
  - Writes in cycles r+1 onward do not affect the read issued in cycle r.
- particle_count:
  - On an accepted write, if wr_addr+1 > particle_count, it becomes wr_addr+1; otherwise it is unchanged.
  - It is zeroed on rst and when a clear sweep starts.
  - Saturation is not needed, because the maximum is DEPTH.
- Out-of-range addresses (addr >= DEPTH when DEPTH < 2**ADDR_WIDTH): writes are dropped and do not update particle_count; reads return zero with rd_valid=1.
- Clear mid-operation:
  - Reads still in the pipeline complete with their pre-clear data and rd_valid.
  - Requests that arrive in the same cycle the FSM enters CLEAR (i.e. while ready=1 and clear=1) are accepted.
- rst mid-operation: the pipeline is flushed; in-flight reads produce no rd_valid.
- RAM is inferable as a simple dual-port block RAM. When READ_LATENCY=2, the output register is enabled.

Decomposition:
- Shared package md_mem_pkg holds:
  - channel index constants CH_X=0, CH_Y=1, CH_Z=2
  - default DATA_WIDTH, DEPTH and ADDR_WIDTH
  - helper function to extract channel slices from packed buses
- One sub-module, sdp_ram_1w1r: a single-channel 1-write/1-read RAM with an optional output register. It is instantiated NUM_CHANNELS times.
- The FSM, bypass compare/mux, valid pipeline and particle counter live in the top level.

Test Plan:
1. Clear sweep timing (DEPTH=16): release rst -> ready=0 for 16 cycles, ready=1 at c16, particle_count=0. Reads of all 16 addresses -> zeros.
2. Read latency (READ_LATENCY=2): write addr 5 with x=0x3F800000, y=0x40000000, z=0x40400000, mask=3'b111. Read addr 5 at cycle r -> rd_valid at r+2 only, with the packed data exact. Repeat with READ_LATENCY=1 -> rd_valid at r+1.
3. Masked write and bypass: with addr 7 holding y=0x11, read and write addr 7 in the same cycle with mask=3'b010, y=0x22 -> returned y=0x22, x/z old. A next read -> y=0x22.
4. Particle count: write addrs 3, 10, 2 -> particle_count 4, 11, 11. Write addr 20 when DEPTH=16 -> dropped, count stays 11.
5. Clear during traffic: issue 3 back-to-back reads, then pulse clear -> those 3 rd_valid return old data. ready=0 for DEPTH cycles. Requests during CLEAR are dropped. After the sweep -> data zero, count 0.
6. Reset mid-read: assert rst one cycle after rd_en -> no rd_valid, and the clear sweep restarts from address 0.
